bcd_scan_decoder: RTL and testbench



---
 rtl/bcd_scan_decoder.sv | 83 ++++++++
 tb/tb_bcd_scan_decoder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_decoder.sv
// Scanned BCD display driver: latches DIGITS packed BCD digits and time-multiplexes them onto
// one shared one-hot decimal bus. Optional leading-zero blanking is enabled by BCD_SCAN_BLANK_EN.
`timescale 1ns/1ps
module bcd_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic [9:0]          dec_out,
  output logic [DIGITS-1:0]   dig_sel,
  output logic                invalid,
  output logic                err_sticky,
  output logic                frame_done,
  output logic                dbg_state
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t              state_q;
  logic [4*DIGITS-1:0] shadow_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;

  logic                scan;
  logic                blank;
  logic                accept;
  logic [3:0]          cur_digit;

  // Handshake: a word transfers on any rising edge where load_valid && load_ready; load_ready
  // rises only in IDLE or on the last cycle of a frame, and an unaccepted offer is simply dropped.
  always_comb begin
    scan       = (state_q == SCAN);
    cur_digit  = shadow_q[4*idx_q +: 4];
    frame_done = scan && (idx_q == IDX_MAX) && (cnt_q == CNT_MAX);
    load_ready = !scan || frame_done;
    accept     = load_valid && load_ready;
`ifdef BCD_SCAN_BLANK_EN
    blank = (idx_q != '0) && ((shadow_q >> (4*idx_q)) == '0);
`else
    blank = 1'b0;
`endif
    dig_sel    = scan ? (DIGITS'(1) << idx_q) : '0;
    invalid    = scan && !blank && (cur_digit > 4'd9);
    dec_out    = (scan && !blank && (cur_digit <= 4'd9)) ? (10'b1 << cur_digit) : '0;
    err_sticky = err_q;
    dbg_state  = state_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      state_q  <= SCAN;
      shadow_q <= bcd_in;
      idx_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else if (scan) begin
      if (invalid) err_q <= 1'b1;
      if (cnt_q == CNT_MAX) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Directed bench for bcd_scan_decoder: a 4-digit/dwell-4 instance scanned through a sequence of
// loaded words, plus a 1-digit/dwell-2 instance for the single-digit boundary.
`timescale 1ns/1ps
module tb_bcd_scan_decoder;

  localparam int DIGITS = 4;
  localparam int DWELL  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] bcd_in = '0;
  logic        load_ready, invalid, err_sticky, frame_done, dbg_state;
  logic [9:0]  dec_out;
  logic [3:0]  dig_sel;

  logic        load_valid2 = 1'b0;
  logic [3:0]  bcd_in2 = '0;
  logic        load_ready2, invalid2, err_sticky2, frame_done2, dbg_state2;
  logic [9:0]  dec_out2;
  logic [0:0]  dig_sel2;

  int n_vec = 0;
  int n_err = 0;
  bit err_m = 1'b0;

  always #5 clk = ~clk;

  bcd_scan_decoder #(.DIGITS(DIGITS), .DWELL(DWELL)) u_dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .bcd_in(bcd_in), .dec_out(dec_out), .dig_sel(dig_sel), .invalid(invalid),
    .err_sticky(err_sticky), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  bcd_scan_decoder #(.DIGITS(1), .DWELL(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid2), .load_ready(load_ready2),
    .bcd_in(bcd_in2), .dec_out(dec_out2), .dig_sel(dig_sel2), .invalid(invalid2),
    .err_sticky(err_sticky2), .frame_done(frame_done2), .dbg_state(dbg_state2)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic st, input logic rdy, input logic [9:0] dec,
                         input logic [3:0] sel, input logic inv, input logic err, input logic fd);
    chk({tag, ".state"}, 32'(dbg_state), 32'(st));
    chk({tag, ".ready"}, 32'(load_ready), 32'(rdy));
    chk({tag, ".dec"}, 32'(dec_out), 32'(dec));
    chk({tag, ".sel"}, 32'(dig_sel), 32'(sel));
    chk({tag, ".inv"}, 32'(invalid), 32'(inv));
    chk({tag, ".err"}, 32'(err_sticky), 32'(err));
    chk({tag, ".fd"}, 32'(frame_done), 32'(fd));
  endtask

  task automatic load(input logic [15:0] w);
    load_valid = 1'b1;
    bcd_in     = w;
    tick();
    load_valid = 1'b0;
    err_m      = 1'b0;
  endtask

  // Walks ncyc cycles of a frame of word w; optionally offers offer_w from cycle offer_at onward.
  task automatic frame(input logic [15:0] w, input int offer_at, input logic [15:0] offer_w,
                       input int ncyc, input string tag);
    for (int c = 0; c < ncyc; c++) begin
      int         ix;
      logic [3:0] d;
      logic       bl;
      logic       inv;
      logic [9:0] ed;
      ix = c / DWELL;
      d  = w[4*ix +: 4];
      bl = 1'b0;
`ifdef BCD_SCAN_BLANK_EN
      bl = (ix > 0) && ((w >> (4*ix)) == 16'h0);
`endif
      inv = (d > 4'd9) && !bl;
      ed  = ((d <= 4'd9) && !bl) ? (10'b1 << d) : 10'b0;
      chk_all($sformatf("%s.c%0d", tag, c), 1'b1, c == 15, ed, 4'(4'b1 << ix), inv, err_m, c == 15);
      if (inv) err_m = 1'b1;
      if (c == offer_at) begin
        load_valid = 1'b1;
        bcd_in     = offer_w;
      end
      if (ncyc == 16 || c < ncyc - 1) tick();
    end
    if (offer_at >= 0 && ncyc == 16) begin
      load_valid = 1'b0;
      err_m      = 1'b0;
    end
  endtask

  initial begin
    #1;
    repeat (3) begin
      tick();
      chk_all("reset", 1'b0, 1'b1, 10'h000, 4'h0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    repeat (20) begin
      tick();
      chk_all("idle", 1'b0, 1'b1, 10'h000, 4'h0, 1'b0, 1'b0, 1'b0);
    end
    chk("idle1.ready", 32'(load_ready2), 32'h1);

    load(16'h4021);
    chk("first_4021.dec", 32'(dec_out), 32'h002);
    frame(16'h4021, -1, 16'h0, 16, "f4021a");
    frame(16'h4021, 4, 16'h9876, 16, "f4021b");
    chk("accept_9876.sel", 32'(dig_sel), 32'h1);
    chk("accept_9876.dec", 32'(dec_out), 32'h040);
    frame(16'h9876, 0, 16'h00C3, 16, "f9876");
    frame(16'h00C3, -1, 16'h0, 16, "fC3a");
    frame(16'h00C3, 10, 16'h0057, 16, "fC3b");
    chk("cleared_0057.err", 32'(err_sticky), 32'h0);
    frame(16'h0057, 5, 16'h0000, 16, "f0057");
    frame(16'h0000, 2, 16'h4021, 16, "f0000");
    frame(16'h4021, -1, 16'h0, 10, "f4021_rst");

    rst_n = 1'b0;
    tick();
    chk_all("midreset", 1'b0, 1'b1, 10'h000, 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_all("postreset", 1'b0, 1'b1, 10'h000, 4'h0, 1'b0, 1'b0, 1'b0);
    err_m = 1'b0;

    load_valid2 = 1'b1;
    bcd_in2     = 4'h7;
    tick();
    load_valid2 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("d1.c%0d.dec", c), 32'(dec_out2), 32'h080);
      chk($sformatf("d1.c%0d.sel", c), 32'(dig_sel2), 32'h1);
      chk($sformatf("d1.c%0d.fd", c), 32'(frame_done2), 32'(c % 2 == 1));
      chk($sformatf("d1.c%0d.ready", c), 32'(load_ready2), 32'(c % 2 == 1));
      if (c == 3) begin
        load_valid2 = 1'b1;
        bcd_in2     = 4'hA;
      end
      tick();
    end
    load_valid2 = 1'b0;
    chk("d1.bad.inv", 32'(invalid2), 32'h1);
    chk("d1.bad.dec", 32'(dec_out2), 32'h000);
    chk("d1.bad.err0", 32'(err_sticky2), 32'h0);
    tick();
    chk("d1.bad.err1", 32'(err_sticky2), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
